// File: rtl/fb_pkg.sv
// Shared constants and FSM type for the VGA frame buffer writer and its raster counter.
// Register map sits at BASE_ADDR+0..+5; FB address format is {Y[6:0], X[7:0]}.
package fb_pkg;
  localparam logic [7:0] BASE_ADDR = 8'hB0;
  localparam logic [7:0] OFF_X     = 8'd0;
  localparam logic [7:0] OFF_Y     = 8'd1;
  localparam logic [7:0] OFF_PIXEL = 8'd2;
  localparam logic [7:0] OFF_COL0  = 8'd3;
  localparam logic [7:0] OFF_COL1  = 8'd4;
  localparam logic [7:0] OFF_CMD   = 8'd5;
  localparam logic [7:0] NUM_REGS  = 8'd6;

  localparam logic [7:0] FB_W      = 8'd160;
  localparam logic [7:0] FB_H      = 8'd120;
  localparam int         FB_ADDR_W = 15;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;
endpackage

// File: rtl/fb_raster_counter.sv
// X/Y raster counter: X fastest, wraps at FB_W then FB_H; per-axis load, clear and count enable.
// done_o is high while the counter sits on the last visible pixel (FB_W-1, FB_H-1).
module fb_raster_counter
  import fb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       ld_x_i,
  input  logic       ld_y_i,
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic       done_o
);
  logic [7:0] x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (ld_x_i || ld_y_i) begin
      if (ld_x_i) x_d = x_i;
      if (ld_y_i) y_d = y_i;
    end else if (en_i) begin
      // Out-of-range loaded values also wrap instead of running past the edge.
      if (x_q >= FB_W - 8'd1) begin
        x_d = '0;
        y_d = (y_q >= FB_H - 8'd1) ? '0 : y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign done_o = (x_q == FB_W - 8'd1) && (y_q == FB_H - 8'd1);
endmodule

// File: rtl/vga_frame_buffer_writer.sv
// Write port of the 160x120x1 frame buffer: bus register decode, pixel writes, colours and fill engine.
// Optional build macro FB_AUTO_INC_EN: X/Y advance in raster order after each accepted pixel write.
module vga_frame_buffer_writer
  import fb_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [7:0]           BUS_ADDR,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_WE,
  input  logic                 BUS_RE,
  output logic [7:0]           BUS_DATA_OUT,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic                 FB_DATA,
  output logic                 FB_WE,
  output logic [15:0]          CONFIG_COLOURS,
  output logic                 BUSY,
  output fill_state_e          DBG_STATE
);
  fill_state_e          state_q, state_d;
  logic                 err_q, err_d;
  logic                 pix_we_q, pix_we_d;
  logic [FB_ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic                 fb_data_q, fb_data_d;
  logic [7:0]           rd_q, rd_d;
  logic [7:0]           col0_q, col0_d, col1_q, col1_d;
  logic [7:0]           x_cur, y_cur;
  logic [7:0]           fill_x, fill_y;
  logic                 fill_done, fill_start, pix_ok, busy;
  logic                 fill_y_msb_unused;

  logic [7:0] off;
  logic       hit, wr_x, wr_y, wr_pix, wr_cmd, rd_status;

  assign off       = BUS_ADDR - BASE_ADDR;
  assign hit       = off < NUM_REGS;
  assign wr_x      = BUS_WE && hit && (off == OFF_X);
  assign wr_y      = BUS_WE && hit && (off == OFF_Y);
  assign wr_pix    = BUS_WE && hit && (off == OFF_PIXEL);
  assign wr_cmd    = BUS_WE && hit && (off == OFF_CMD);
  assign rd_status = BUS_RE && hit && (off == OFF_CMD);
  assign busy      = (state_q == FILL);

  // Fill counter holds the pixel currently presented on FB_ADDR while filling.
  fb_raster_counter u_fill_cnt (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .clr_i  (fill_start),
    .en_i   (busy && !fill_done),
    .ld_x_i (1'b0),
    .ld_y_i (1'b0),
    .x_i    (8'd0),
    .y_i    (8'd0),
    .x_o    (fill_x),
    .y_o    (fill_y),
    .done_o (fill_done)
  );
  assign fill_y_msb_unused = fill_y[7];

`ifdef FB_AUTO_INC_EN
  logic xy_done_unused;
  fb_raster_counter u_xy_cnt (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .clr_i  (1'b0),
    .en_i   (pix_ok),
    .ld_x_i (wr_x),
    .ld_y_i (wr_y),
    .x_i    (BUS_DATA_IN),
    .y_i    (BUS_DATA_IN),
    .x_o    (x_cur),
    .y_o    (y_cur),
    .done_o (xy_done_unused)
  );
`else
  logic [7:0] x_q, x_d, y_q, y_d;
  always_comb begin
    x_d = wr_x ? BUS_DATA_IN : x_q;
    y_d = wr_y ? BUS_DATA_IN : y_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign x_cur = x_q;
  assign y_cur = y_q;
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    fb_data_d  = fb_data_q;
    col0_d     = (BUS_WE && hit && off == OFF_COL0) ? BUS_DATA_IN : col0_q;
    col1_d     = (BUS_WE && hit && off == OFF_COL1) ? BUS_DATA_IN : col1_q;
    rd_d       = '0;
    fill_start = 1'b0;
    pix_ok     = 1'b0;

    // Clear-on-read comes first so a same-cycle error still lands.
    if (rd_status) err_d = 1'b0;

    if (wr_pix) begin
      if (busy || x_cur >= FB_W || y_cur >= FB_H) begin
        err_d = 1'b1;
      end else begin
        pix_ok     = 1'b1;
        pix_we_d   = 1'b1;
        pix_addr_d = {y_cur[6:0], x_cur};
        fb_data_d  = BUS_DATA_IN[0];
      end
    end

    if (wr_cmd && BUS_DATA_IN[0]) begin
      if (busy) begin
        err_d = 1'b1;
      end else begin
        fill_start = 1'b1;
        state_d    = FILL;
        fb_data_d  = BUS_DATA_IN[1];
      end
    end

    if (busy && fill_done) state_d = IDLE;

    if (BUS_RE && hit) begin
      case (off)
        OFF_X:     rd_d = x_cur;
        OFF_Y:     rd_d = y_cur;
        OFF_PIXEL: rd_d = {7'b0, fb_data_q};
        OFF_COL0:  rd_d = col0_q;
        OFF_COL1:  rd_d = col1_q;
        OFF_CMD:   rd_d = {6'b0, err_q, busy};
        default:   rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      fb_data_q  <= 1'b0;
      rd_q       <= '0;
      col0_q     <= 8'h00;
      col1_q     <= 8'hFF;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      fb_data_q  <= fb_data_d;
      rd_q       <= rd_d;
      col0_q     <= col0_d;
      col1_q     <= col1_d;
    end
  end

  // Both sources are registers and never active together, so the mux stays glitch-free.
  assign FB_WE          = pix_we_q | busy;
  assign FB_ADDR        = busy ? {fill_y[6:0], fill_x} : pix_addr_q;
  assign FB_DATA        = fb_data_q;
  assign BUSY           = busy;
  assign BUS_DATA_OUT   = rd_q;
  assign CONFIG_COLOURS = {col1_q, col0_q};
  assign DBG_STATE      = state_q;
endmodule

// File: tb/tb_vga_frame_buffer_writer.sv
// Directed bench for vga_frame_buffer_writer: pixel writes, colours, fill engine, status and reset.
module tb_vga_frame_buffer_writer;
  import fb_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  BUS_ADDR = '0;
  logic [7:0]  BUS_DATA_IN = '0;
  logic        BUS_WE = 1'b0;
  logic        BUS_RE = 1'b0;
  logic [7:0]  BUS_DATA_OUT;
  logic [14:0] FB_ADDR;
  logic        FB_DATA;
  logic        FB_WE;
  logic [15:0] CONFIG_COLOURS;
  logic        BUSY;
  fill_state_e DBG_STATE;

  int tests_run = 0;
  int tests_failed = 0;

  // Fill monitor state
  logic        mon_en = 1'b0;
  int          we_cnt, busy_cnt, addr_err, data_err, bad_x;
  logic [14:0] first_addr, last_addr;
  logic        exp_fill_data;

  vga_frame_buffer_writer dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BUS_ADDR       (BUS_ADDR),
    .BUS_DATA_IN    (BUS_DATA_IN),
    .BUS_WE         (BUS_WE),
    .BUS_RE         (BUS_RE),
    .BUS_DATA_OUT   (BUS_DATA_OUT),
    .FB_ADDR        (FB_ADDR),
    .FB_DATA        (FB_DATA),
    .FB_WE          (FB_WE),
    .CONFIG_COLOURS (CONFIG_COLOURS),
    .BUSY           (BUSY),
    .DBG_STATE      (DBG_STATE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (BUSY) busy_cnt++;
      if (FB_WE) begin
        logic [7:0] ex, ey;
        ex = 8'(we_cnt % 160);
        ey = 8'(we_cnt / 160);
        if (we_cnt == 0) first_addr = FB_ADDR;
        last_addr = FB_ADDR;
        if (FB_ADDR !== {ey[6:0], ex}) addr_err++;
        if (FB_DATA !== exp_fill_data) data_err++;
        if (FB_ADDR[7:0] >= 8'd160) bad_x++;
        we_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a negedge; outputs of the access are visible on return.
  task automatic bus_wr(input logic [7:0] off, input logic [7:0] d);
    BUS_ADDR = BASE_ADDR + off;
    BUS_DATA_IN = d;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] off);
    BUS_ADDR = BASE_ADDR + off;
    BUS_RE = 1'b1;
    @(negedge CLK);
    BUS_RE = 1'b0;
  endtask

  task automatic mon_reset(input logic d);
    we_cnt = 0; busy_cnt = 0; addr_err = 0; data_err = 0; bad_x = 0;
    first_addr = '1; last_addr = '1; exp_fill_data = d;
  endtask

  initial begin
    mon_reset(1'b1);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    check("rst_fb_we", 32'(FB_WE), 32'd0);
    check("rst_fb_addr", 32'(FB_ADDR), 32'd0);
    check("rst_fb_data", 32'(FB_DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_state", 32'(DBG_STATE), 32'd0);
    check("rst_colours", 32'(CONFIG_COLOURS), 32'hFF00);
    check("rst_rdata", 32'(BUS_DATA_OUT), 32'd0);

    // Single pixel at (5,3)
    bus_wr(OFF_X, 8'd5);
    bus_wr(OFF_Y, 8'd3);
    bus_rd(OFF_X);
    check("rd_x", 32'(BUS_DATA_OUT), 32'd5);
    @(negedge CLK);
    check("rd_idle_zero", 32'(BUS_DATA_OUT), 32'd0);
    bus_wr(OFF_PIXEL, 8'h01);
    check("pix_we", 32'(FB_WE), 32'd1);
    check("pix_addr", 32'(FB_ADDR), 32'h0305);
    check("pix_data", 32'(FB_DATA), 32'd1);
    @(negedge CLK);
    check("pix_we_pulse", 32'(FB_WE), 32'd0);

    // Colours
    bus_wr(OFF_COL0, 8'h1C);
    check("col0_only", 32'(CONFIG_COLOURS), 32'hFF1C);
    bus_wr(OFF_COL1, 8'hE0);
    check("colours", 32'(CONFIG_COLOURS), 32'hE01C);
    bus_rd(OFF_COL0);
    check("rd_col0", 32'(BUS_DATA_OUT), 32'h1C);
    BUS_ADDR = 8'hB6;
    BUS_RE = 1'b1;
    @(negedge CLK);
    BUS_RE = 1'b0;
    check("rd_unmapped", 32'(BUS_DATA_OUT), 32'd0);

    // Out-of-range pixel writes
    bus_wr(OFF_X, 8'd160);
    bus_wr(OFF_PIXEL, 8'h01);
    check("oor_x_no_we", 32'(FB_WE), 32'd0);
    bus_rd(OFF_CMD);
    check("oor_x_status", 32'(BUS_DATA_OUT), 32'h02);
    bus_rd(OFF_CMD);
    check("err_cleared", 32'(BUS_DATA_OUT), 32'h00);
    bus_wr(OFF_X, 8'd0);
    bus_wr(OFF_Y, 8'd120);
    bus_wr(OFF_PIXEL, 8'h01);
    check("oor_y_no_we", 32'(FB_WE), 32'd0);
    bus_rd(OFF_CMD);
    check("oor_y_status", 32'(BUS_DATA_OUT), 32'h02);

    // Last visible pixel, value 0
    bus_wr(OFF_X, 8'd159);
    bus_wr(OFF_Y, 8'd119);
    bus_wr(OFF_PIXEL, 8'h00);
    check("edge_we", 32'(FB_WE), 32'd1);
    check("edge_addr", 32'(FB_ADDR), 32'h779F);
    check("edge_data", 32'(FB_DATA), 32'd0);

    // Full fill with value 1, pixel write mid-fill
    bus_wr(OFF_X, 8'd7);
    bus_wr(OFF_Y, 8'd2);
    mon_reset(1'b1);
    mon_en = 1'b1;
    bus_wr(OFF_CMD, 8'h03);
    check("fill_busy_n1", 32'(BUSY), 32'd1);
    check("fill_first_we", 32'(FB_WE), 32'd1);
    check("fill_first_addr", 32'(FB_ADDR), 32'h0000);
    repeat (50) @(negedge CLK);
    bus_wr(OFF_PIXEL, 8'h00);
    bus_rd(OFF_CMD);
    check("fill_status", 32'(BUS_DATA_OUT), 32'h03);
    bus_wr(OFF_CMD, 8'h01);
    begin
      int cyc;
      for (cyc = 0; cyc < 20000; cyc++) begin
        if (!BUSY) break;
        @(negedge CLK);
      end
      check("fill_timeout", 32'(cyc < 20000), 32'd1);
    end
    mon_en = 1'b0;
    check("fill_we_count", 32'(we_cnt), 32'd19200);
    check("fill_busy_count", 32'(busy_cnt), 32'd19200);
    check("fill_addr_seq", 32'(addr_err), 32'd0);
    check("fill_data", 32'(data_err), 32'd0);
    check("fill_bad_x", 32'(bad_x), 32'd0);
    check("fill_first", 32'(first_addr), 32'h0000);
    check("fill_last", 32'(last_addr), 32'h779F);
    check("fill_end_state", 32'(DBG_STATE), 32'd0);
    check("fill_end_we", 32'(FB_WE), 32'd0);
    bus_rd(OFF_CMD);
    check("fill_status_err", 32'(BUS_DATA_OUT), 32'h02);
    bus_rd(OFF_CMD);
    check("post_fill_status", 32'(BUS_DATA_OUT), 32'h00);
    bus_rd(OFF_X);
    check("fill_x_kept", 32'(BUS_DATA_OUT), 32'd7);

    // Reset at fill cycle 100
    bus_wr(OFF_CMD, 8'h01);
    check("fill0_data", 32'(FB_DATA), 32'd0);
    repeat (99) @(negedge CLK);
    check("fill100_busy", 32'(BUSY), 32'd1);
    check("fill100_addr", 32'(FB_ADDR), 32'd99);
    RESET = 1'b1;
    @(negedge CLK);
    check("rstfill_we", 32'(FB_WE), 32'd0);
    check("rstfill_busy", 32'(BUSY), 32'd0);
    check("rstfill_state", 32'(DBG_STATE), 32'd0);
    check("rstfill_colours", 32'(CONFIG_COLOURS), 32'hFF00);
    RESET = 1'b0;
    begin
      int stray;
      stray = 0;
      repeat (5) begin
        @(negedge CLK);
        if (FB_WE) stray++;
      end
      check("rstfill_no_more_we", 32'(stray), 32'd0);
    end

`ifdef FB_AUTO_INC_EN
    bus_wr(OFF_X, 8'd159);
    bus_wr(OFF_Y, 8'd119);
    bus_wr(OFF_PIXEL, 8'h01);
    check("ainc_addr0", 32'(FB_ADDR), 32'h779F);
    bus_wr(OFF_PIXEL, 8'h01);
    check("ainc_we1", 32'(FB_WE), 32'd1);
    check("ainc_addr1", 32'(FB_ADDR), 32'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
